// File: rtl/key_deser.sv
// Serial key deserializer: frames of KEY_W bits (MSB first) assembled into a held key.
// Define KEY_PARITY_EN to require a trailing parity bit per frame before the key is presented.
module key_deser #(
  parameter int KEY_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sin_start,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             key_ack,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int GAP_W = $clog2(TIMEOUT + 1);

`ifdef KEY_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, HOLD = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd3} state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
  logic [KEY_W-1:0]   shift_q, shift_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               frameErr_q, frameErr_d;
  logic [KEY_W-1:0]   assembled;
  logic               timeoutHit;

  assign assembled  = {shift_q[KEY_W-2:0], sin_data};
  assign timeoutHit = !sin_valid && (gapCnt_q == GAP_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      gapCnt_q   <= '0;
      shift_q    <= '0;
      key_q      <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      gapCnt_q   <= gapCnt_d;
      shift_q    <= shift_d;
      key_q      <= key_d;
      frameErr_q <= frameErr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    gapCnt_d   = gapCnt_q;
    shift_d    = shift_q;
    key_d      = key_q;
    frameErr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sin_start) begin
          state_d  = SHIFT;
          bitCnt_d = '0;
          gapCnt_d = '0;
          shift_d  = '0;
        end
      end
      SHIFT: begin
        // A new start outranks any bit arriving in the same cycle
        if (sin_start) begin
          frameErr_d = 1'b1;
          bitCnt_d   = '0;
          gapCnt_d   = '0;
          shift_d    = '0;
        end else if (sin_valid) begin
          gapCnt_d = '0;
          shift_d  = assembled;
          if (bitCnt_q == CNT_W'(KEY_W - 1)) begin
`ifdef KEY_PARITY_EN
            state_d  = PAR;
            bitCnt_d = bitCnt_q + CNT_W'(1);
`else
            state_d  = HOLD;
            key_d    = assembled;
            bitCnt_d = '0;
`endif
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end else if (timeoutHit) begin
          state_d    = IDLE;
          frameErr_d = 1'b1;
          bitCnt_d   = '0;
          gapCnt_d   = '0;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
      end
`ifdef KEY_PARITY_EN
      PAR: begin
        if (sin_start) begin
          state_d    = SHIFT;
          frameErr_d = 1'b1;
          bitCnt_d   = '0;
          gapCnt_d   = '0;
          shift_d    = '0;
        end else if (sin_valid) begin
          bitCnt_d = '0;
          gapCnt_d = '0;
          // Accepted parity bit equals the XNOR of the key bits
          if (sin_data == ~^shift_q) begin
            state_d = HOLD;
            key_d   = shift_q;
          end else begin
            state_d    = IDLE;
            frameErr_d = 1'b1;
          end
        end else if (timeoutHit) begin
          state_d    = IDLE;
          frameErr_d = 1'b1;
          bitCnt_d   = '0;
          gapCnt_d   = '0;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
      end
`endif
      HOLD: begin
        if (key_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign key       = key_q;
  assign key_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_key_deser.sv
// Self-checking bench for key_deser: directed scenarios plus randomized frames against a bit-queue model.
// Parity scenarios are compiled in when KEY_PARITY_EN is defined.
module tb_key_deser;

  localparam int KEY_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk;
  logic             rstn;
  logic             sin_start;
  logic             sin_valid;
  logic             sin_data;
  logic             key_ack;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             busy;
  logic             frame_err;

  int errors;
  int checks;
  logic [KEY_W-1:0] lastKey;
  bit sentBits[$];

  key_deser #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sin_start (sin_start),
    .sin_valid (sin_valid),
    .sin_data  (sin_data),
    .key_ack   (key_ack),
    .key       (key),
    .key_valid (key_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are observed there too.
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic startFrame();
    sin_start = 1'b1;
    cycle();
    sin_start = 1'b0;
    sentBits.delete();
  endtask

  task automatic sendBit(input bit b);
    sin_valid = 1'b1;
    sin_data  = b;
    cycle();
    sin_valid = 1'b0;
    sin_data  = 1'b0;
  endtask

  task automatic sendData(input logic [KEY_W-1:0] k, input int maxGap);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (i != KEY_W - 1 && maxGap > 0) repeat ($urandom_range(maxGap, 0)) cycle();
      sentBits.push_back(k[i]);
      sendBit(k[i]);
    end
  endtask

  function automatic bit parityOf(input logic [KEY_W-1:0] k);
    int ones = 0;
    for (int i = 0; i < KEY_W; i++) ones += int'(k[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic sendKey(input logic [KEY_W-1:0] k, input int maxGap);
    sendData(k, maxGap);
`ifdef KEY_PARITY_EN
    sendBit(parityOf(k));
`endif
  endtask

  function automatic logic [KEY_W-1:0] modelKey();
    int v = 0;
    for (int i = 0; i < KEY_W; i++) v = v * 2 + int'(sentBits[i]);
    return KEY_W'(v);
  endfunction

  task automatic ackKey();
    key_ack = 1'b1;
    cycle();
    key_ack = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    cycle();
    cycle();
    checks++; if (key !== '0) begin errors++; $display("[TB] FAIL reset_key got=%h exp=%h", key, 8'h00); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_valid got=%b exp=0", key_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
    rstn = 1'b1;
    cycle();
    lastKey = '0;
  endtask

  task automatic test_basic_frame();
    startFrame();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_after_start got=%b exp=1", busy); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_valid_early got=%b exp=0", key_valid); end
    sendKey(8'hA4, 0);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_key_valid got=%b exp=1", key_valid); end
    checks++; if (key !== 8'hA4) begin errors++; $display("[TB] FAIL basic_key got=%h exp=a4", key); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_frame_err got=%b exp=0", frame_err); end
    lastKey = 8'hA4;
  endtask

  task automatic test_hold_ack();
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (key_valid !== 1'b1 || key !== 8'hA4) begin
        errors++; $display("[TB] FAIL hold_stable cyc=%0d got valid=%b key=%h exp valid=1 key=a4", i, key_valid, key);
      end
    end
    ackKey();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_valid_low got=%b exp=0", key_valid); end
    checks++; if (key !== 8'hA4) begin errors++; $display("[TB] FAIL ack_key_kept got=%h exp=a4", key); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ack_busy got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    int firstHit = 0;
    int pulses = 0;
    startFrame();
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    for (int j = 1; j <= TIMEOUT + 4; j++) begin
      cycle();
      if (frame_err === 1'b1) begin
        pulses++;
        if (firstHit == 0) firstHit = j;
      end
    end
    checks++; if (firstHit != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_cycle got=%0d exp=%0d", firstHit, TIMEOUT); end
    checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL timeout_pulses got=%0d exp=1", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle got busy=%b exp=0", busy); end
    checks++; if (key !== lastKey || key_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_key got key=%h valid=%b exp key=%h valid=0", key, key_valid, lastKey);
    end
  endtask

  task automatic test_restart();
    startFrame();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sin_start = 1'b1;
    sin_valid = 1'b1;
    sin_data  = 1'b1;
    cycle();
    sin_start = 1'b0;
    sin_valid = 1'b0;
    sin_data  = 1'b0;
    sentBits.delete();
    checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL restart_frame_err got=%b exp=1", frame_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL restart_busy got=%b exp=1", busy); end
    sendKey(8'h7E, 0);
    checks++; if (key !== 8'h7E || key_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL restart_key got key=%h valid=%b exp key=7e valid=1", key, key_valid);
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL restart_err_cleared got=%b exp=0", frame_err); end
    lastKey = 8'h7E;
    ackKey();
  endtask

  task automatic test_reset_midframe();
    int sawValid = 0;
    startFrame();
    for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(1, 0)));
    #2 rstn = 1'b0;
    #1;
    checks++; if (key !== '0 || key_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs got key=%h valid=%b busy=%b err=%b exp all 0", key, key_valid, busy, frame_err);
    end
    cycle();
    rstn = 1'b1;
    lastKey = '0;
    for (int i = 0; i < KEY_W + 2; i++) begin
      sendBit(1'($urandom_range(1, 0)));
      if (key_valid === 1'b1 || busy === 1'b1) sawValid++;
    end
    repeat (3) begin
      cycle();
      if (key_valid === 1'b1 || busy === 1'b1) sawValid++;
    end
    checks++; if (sawValid != 0) begin errors++; $display("[TB] FAIL midreset_no_frame got=%0d active cycles exp=0", sawValid); end
    checks++; if (key !== '0) begin errors++; $display("[TB] FAIL midreset_key got=%h exp=00", key); end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 24; n++) begin
      logic [KEY_W-1:0] k;
      logic [KEY_W-1:0] expKey;
      k = KEY_W'($urandom);
      startFrame();
      if ($urandom_range(3, 0) == 0) begin
        for (int i = 0; i < int'($urandom_range(KEY_W - 1, 1)); i++) sendBit(1'($urandom_range(1, 0)));
        checks++; if (key !== lastKey || key_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL rand_partial n=%0d got key=%h valid=%b exp key=%h valid=0", n, key, key_valid, lastKey);
        end
        sin_start = 1'b1;
        sin_valid = 1'($urandom_range(1, 0));
        sin_data  = 1'($urandom_range(1, 0));
        cycle();
        sin_start = 1'b0;
        sin_valid = 1'b0;
        sentBits.delete();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL rand_restart_err n=%0d got=%b exp=1", n, frame_err); end
      end
      sendKey(k, 3);
      expKey = modelKey();
      checks++; if (key !== expKey || key_valid !== 1'b1 || frame_err !== 1'b0) begin
        errors++; $display("[TB] FAIL rand_key n=%0d got key=%h valid=%b err=%b exp key=%h valid=1 err=0", n, key, key_valid, frame_err, expKey);
      end
      lastKey = expKey;
      repeat ($urandom_range(4, 0)) begin
        sin_start = 1'($urandom_range(1, 0));
        sin_valid = 1'($urandom_range(1, 0));
        sin_data  = 1'($urandom_range(1, 0));
        cycle();
        checks++; if (key !== expKey || key_valid !== 1'b1 || frame_err !== 1'b0) begin
          errors++; $display("[TB] FAIL rand_hold n=%0d got key=%h valid=%b err=%b exp key=%h valid=1 err=0", n, key, key_valid, frame_err, expKey);
        end
      end
      sin_start = 1'b0;
      sin_valid = 1'b0;
      sin_data  = 1'b0;
      ackKey();
      checks++; if (key_valid !== 1'b0 || busy !== 1'b0 || key !== expKey) begin
        errors++; $display("[TB] FAIL rand_ack n=%0d got valid=%b busy=%b key=%h exp valid=0 busy=0 key=%h", n, key_valid, busy, key, expKey);
      end
    end
  endtask

`ifdef KEY_PARITY_EN
  task automatic test_parity();
    startFrame();
    sendData(8'hA4, 0);
    sendBit(1'b1);
    checks++; if (frame_err !== 1'b1 || key_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL parity_bad got err=%b valid=%b busy=%b exp err=1 valid=0 busy=0", frame_err, key_valid, busy);
    end
    checks++; if (key !== lastKey) begin errors++; $display("[TB] FAIL parity_bad_key got=%h exp=%h", key, lastKey); end
    startFrame();
    sendData(8'hA4, 0);
    sendBit(1'b0);
    checks++; if (key !== 8'hA4 || key_valid !== 1'b1 || frame_err !== 1'b0) begin
      errors++; $display("[TB] FAIL parity_good got key=%h valid=%b err=%b exp key=a4 valid=1 err=0", key, key_valid, frame_err);
    end
    lastKey = 8'hA4;
    ackKey();
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    lastKey   = '0;
    sin_start = 1'b0;
    sin_valid = 1'b0;
    sin_data  = 1'b0;
    key_ack   = 1'b0;
    rstn      = 1'b1;
    test_reset();
    test_basic_frame();
    test_hold_ack();
    test_timeout();
    test_restart();
    test_reset_midframe();
    test_random_frames();
`ifdef KEY_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
